// File: rtl/wadd_strobe_decoder.sv
// ---------------------------------------------------------------------------
// wadd_strobe_decoder
//
// Registered write-address decoder for register-file write ports. One write
// address is accepted per valid/ready handshake. An in-range address drives a
// one-hot strobe on the matching io_CTRL line for STROBE_LEN cycles. After the
// strobe, the block waits GAP_LEN turnaround cycles before it accepts again.
// An out-of-range address produces no strobe. Instead it sets a sticky error
// flag, and the block stays ready.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   io_valid    in   1       io_WADD is valid this cycle
//   io_ready    out  1       block can accept an address this cycle
//   io_WADD     in   ADDR_W  write address to decode
//   io_CTRL     out  N_OUT   registered one-hot write strobes
//   io_busy     out  1       strobe or turnaround gap in progress
//   io_err      out  1       sticky: an out-of-range address was accepted
//   io_err_clr  in   1       clears io_err (a simultaneous new error wins)
// ---------------------------------------------------------------------------
module wadd_strobe_decoder #(
    parameter int ADDR_W     = 2,
    parameter int N_OUT      = 4,
    parameter int STROBE_LEN = 1,
    parameter int GAP_LEN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_valid,
    output logic              io_ready,
    input  logic [ADDR_W-1:0] io_WADD,
    output logic [N_OUT-1:0]  io_CTRL,
    output logic              io_busy,
    output logic              io_err,
    input  logic              io_err_clr
);

    // The counter must be wide enough to hold the longer of the two phase lengths.
    localparam int MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int CNT_W   = ($clog2(MAX_LEN + 1) < 1) ? 1 : $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
    logic [N_OUT-1:0]   ctrl_reg,  ctrl_next;
    logic               err_reg,   err_next;

    logic               accept;
    logic               in_range;
    logic [N_OUT-1:0]   decoded;

    // One comparator for each output line. At most one of them can match.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_dec
            assign decoded[gi] = (io_WADD == ADDR_W'(gi));
        end
    endgenerate

    // When every address maps to a line, the range check is constant true.
    // In that case io_err can never be set.
    generate
        if (N_OUT >= (1 << ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = ({1'b0, io_WADD} < (ADDR_W + 1)'(N_OUT));
        end
    endgenerate

    assign io_ready = (state_reg == IDLE);
    assign io_busy  = (state_reg != IDLE);
    assign accept   = io_valid && io_ready;
    assign io_CTRL  = ctrl_reg;
    assign io_err   = err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ctrl_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ctrl_reg  <= ctrl_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ctrl_next  = ctrl_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (accept && in_range) begin
                    state_next = STROBE;
                    ctrl_next  = decoded;
                    cnt_next   = CNT_W'(STROBE_LEN - 1);
                end
            end
            STROBE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    ctrl_next = '0;
                    if (GAP_LEN > 0) begin
                        state_next = GAP;
                        cnt_next   = CNT_W'(GAP_LEN - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ctrl_next  = '0;
                cnt_next   = '0;
            end
        endcase

        // The clear is applied first, so a new error in the same cycle wins.
        if (io_err_clr) begin
            err_next = 1'b0;
        end
        if (accept && !in_range) begin
            err_next = 1'b1;
        end
    end

endmodule
